// File: rtl/logic_engine_pkg.sv
// Shared types and opcode constants for the logic_engine arbiter slice.
package logic_engine_pkg;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Requester identifier: 0 or 1
  typedef logic req_id_t;

endpackage

// File: rtl/logic_engine.sv
// Combinational bitwise logic engine: OR / NAND / NOR / AND on WIDTH-bit operands.
import logic_engine_pkg::*;

module logic_engine #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] y_o
);

  // Opcode decode; purely bitwise, no carries
  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_OR:   y_o = a_i | b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_AND:  y_o = a_i & b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_engine_arbiter.sv
// Two-requester round-robin front end for a single logic_engine.
// One operation in flight: IDLE (arbitrate/accept) -> EXEC (compute) -> RESP (hold until taken).
// Optional per-requester grant counters: define LOGIC_ENGINE_ARB_STATS_EN.
import logic_engine_pkg::*;

module logic_engine_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id
`ifdef LOGIC_ENGINE_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_e           state_q, state_d;
  req_id_t          last_grant_q, id_q, win;
  logic [WIDTH-1:0] a_q, b_q, eng_y, rsp_data_q;
  logic [1:0]       op_q;
  logic             rsp_valid_q, rsp_id_q;
  logic             accept;

  // Round-robin pick; ready only in IDLE and only toward the winner
  always_comb begin
    if (req0_valid && req1_valid) win = ~last_grant_q;
    else if (req1_valid)          win = 1'b1;
    else                          win = 1'b0;
    req0_ready = (state_q == ST_IDLE) && req0_valid && (win == 1'b0);
    req1_ready = (state_q == ST_IDLE) && req1_valid && (win == 1'b1);
    accept     = req0_ready | req1_ready;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Capture the winner's operands and remember who was served
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
    end else if (accept) begin
      a_q          <= win ? req1_a  : req0_a;
      b_q          <= win ? req1_b  : req0_b;
      op_q         <= win ? req1_op : req0_op;
      id_q         <= win;
      last_grant_q <= win;
    end
  end

  logic_engine #(.WIDTH(WIDTH)) u_engine (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .y_o  (eng_y)
  );

  // Response register: loaded in EXEC, held through RESP until consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= eng_y;
      rsp_id_q    <= id_q;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef LOGIC_ENGINE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Per-requester accept counters, wrapping modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready) cnt0_q <= cnt0_q + 1'b1;
      if (req1_ready) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule
